// File: rtl/priority_request_encoder.sv
// Purpose : collects sticky request strobes and grants the lowest-numbered pending one.
// Latency : req sampled at edge t -> pend after t, grant (V=1) after t+1 when E=1.
// Backpressure: a grant holds D/V stable until ack; one idle bubble follows each ack.
//
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - synchronous active-low reset
//   req   - 32 request strobes, ORed into the pending register every cycle
//   E     - grant enable, only consulted when no grant is outstanding
//   ack   - consumer accepts the presented index (ignored while V=0)
//   D     - registered index of the granted request (0 while V=0)
//   V     - registered valid for D
//   pend  - pending-request register
//   cnt   - population count of pend, combinational
module priority_request_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req,
    input  logic        E,
    input  logic        ack,
    output logic [4:0]  D,
    output logic        V,
    output logic [31:0] pend,
    output logic [5:0]  cnt
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic        r_state;
    logic [31:0] r_pend;
    logic [4:0]  r_d;

    logic [4:0]  w_low_idx;
    logic        w_any;
    logic [31:0] w_clr_mask;
    logic [31:0] w_pend_nxt;
    logic [5:0]  w_cnt;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        w_low_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_low_idx = 5'(i);
            end
        end
    end

    assign w_any = |r_pend;

    // The clear is applied before the OR so a same-edge request re-sets the bit.
    assign w_clr_mask = ((r_state == ST_GRANT) && ack) ? (32'd1 << r_d) : 32'd0;
    assign w_pend_nxt = (r_pend & ~w_clr_mask) | req;

    always_comb begin
        w_cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            w_cnt = w_cnt + {5'd0, r_pend[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pend  <= 32'd0;
            r_d     <= 5'd0;
        end else begin
            r_pend <= w_pend_nxt;
            if (r_state == ST_IDLE) begin
                // Grant decision uses the pend value before this edge's requests.
                if (E && w_any) begin
                    r_state <= ST_GRANT;
                    r_d     <= w_low_idx;
                end
            end else begin
                if (ack) begin
                    r_state <= ST_IDLE;
                    r_d     <= 5'd0;
                end
            end
        end
    end

    assign D    = r_d;
    assign V    = (r_state == ST_GRANT);
    assign pend = r_pend;
    assign cnt  = w_cnt;

endmodule

// File: tb/tb_priority_request_encoder.sv
// Purpose : self-checking bench for priority_request_encoder.
// Latency : one check per clock, sampled 1 time unit after the rising edge.
// Backpressure: ack driven directly by the bench.
module tb_priority_request_encoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] req;
    logic        E;
    logic        ack;
    logic [4:0]  D;
    logic        V;
    logic [31:0] pend;
    logic [5:0]  cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: what the outputs should be after the last edge.
    logic [31:0] m_pend = 32'd0;
    logic        m_v    = 1'b0;
    logic [4:0]  m_d    = 5'd0;

    priority_request_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .E     (E),
        .ack   (ack),
        .D     (D),
        .V     (V),
        .pend  (pend),
        .cnt   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [31:0] req;
        logic        e;
        logic        ack;
        logic [31:0] pend;
        logic        v;
        logic [4:0]  d;
        logic [5:0]  cnt;
    } vec_t;

    vec_t tbl[14];

    // Index of the lowest set bit: isolate it, then count the ones beneath it.
    function automatic logic [4:0] lowest(input logic [31:0] p);
        logic [31:0] iso;
        iso = p & (~p + 32'd1);
        return 5'($countones(iso - 32'd1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_all(input string nm, input logic [31:0] e_pend, input logic e_v,
                           input logic [4:0] e_d, input logic [5:0] e_cnt);
        chk({nm, ".pend"}, pend, e_pend);
        chk({nm, ".V"}, {31'd0, V}, {31'd0, e_v});
        chk({nm, ".D"}, {27'd0, D}, {27'd0, e_d});
        chk({nm, ".cnt"}, {26'd0, cnt}, {26'd0, e_cnt});
    endtask

    // Drive one cycle of inputs, advance the reference model across the edge,
    // then settle just after the edge.
    task automatic step(input logic r, input logic [31:0] q, input logic e, input logic a);
        logic [31:0] np;
        rst_n = r;
        req   = q;
        E     = e;
        ack   = a;
        if (!r) begin
            m_pend = 32'd0;
            m_v    = 1'b0;
            m_d    = 5'd0;
        end else begin
            np = m_pend | q;
            if (m_v) begin
                if (a) begin
                    if (!q[m_d]) np[m_d] = 1'b0;
                    m_v = 1'b0;
                    m_d = 5'd0;
                end
            end else if (e && (m_pend != 32'd0)) begin
                m_v = 1'b1;
                m_d = lowest(m_pend);
            end
            m_pend = np;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        r, e, a;
        logic [31:0] q;

        rst_n = 1'b0;
        req   = 32'd0;
        E     = 1'b0;
        ack   = 1'b0;

        //           rst   req            E     ack   pend           V     D      cnt
        tbl[0]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 5'd0,  6'd0};
        tbl[1]  = '{1'b1, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 5'd0,  6'd1};
        tbl[2]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 5'd0,  6'd1};
        tbl[3]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 5'd0,  6'd0};
        tbl[4]  = '{1'b1, 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0010, 1'b0, 5'd0,  6'd2};
        tbl[5]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0010, 1'b1, 5'd4,  6'd2};
        tbl[6]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 5'd0,  6'd1};
        tbl[7]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 5'd31, 6'd1};
        tbl[8]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 5'd0,  6'd0};
        tbl[9]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 5'd0,  6'd0};
        tbl[10] = '{1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0040, 1'b0, 5'd0,  6'd1};
        tbl[11] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 5'd0,  6'd1};
        tbl[12] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0040, 1'b1, 5'd6,  6'd1};
        tbl[13] = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 5'd0,  6'd0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst_n, tbl[i].req, tbl[i].e, tbl[i].ack);
            chk_all($sformatf("tbl%0d", i), tbl[i].pend, tbl[i].v, tbl[i].d, tbl[i].cnt);
        end

        // Enable held low: requests accumulate, no grant until E rises.
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b0, 1'b0);
        chk_all("en_off.load", 32'h0000_0100, 1'b0, 5'd0, 6'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'd0, 1'b0, 1'b0);
            chk_all($sformatf("en_off.hold%0d", i), 32'h0000_0100, 1'b0, 5'd0, 6'd1);
        end
        step(1'b1, 32'd0, 1'b1, 1'b0);
        chk_all("en_off.rise", 32'h0000_0100, 1'b1, 5'd8, 6'd1);
        step(1'b1, 32'd0, 1'b1, 1'b1);
        chk_all("en_off.ack", 32'h0000_0000, 1'b0, 5'd0, 6'd0);

        // Lower-index arrival during a grant does not disturb D.
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0020, 1'b1, 1'b0);
        step(1'b1, 32'd0, 1'b1, 1'b0);
        chk_all("lowarr.grant5", 32'h0000_0020, 1'b1, 5'd5, 6'd1);
        step(1'b1, 32'h0000_0004, 1'b1, 1'b0);
        chk_all("lowarr.pulse2", 32'h0000_0024, 1'b1, 5'd5, 6'd2);
        step(1'b1, 32'd0, 1'b0, 1'b0);
        chk_all("lowarr.e_low", 32'h0000_0024, 1'b1, 5'd5, 6'd2);
        step(1'b1, 32'd0, 1'b1, 1'b1);
        chk_all("lowarr.bubble", 32'h0000_0004, 1'b0, 5'd0, 6'd1);
        step(1'b1, 32'd0, 1'b1, 1'b0);
        chk_all("lowarr.grant2", 32'h0000_0004, 1'b1, 5'd2, 6'd1);
        step(1'b1, 32'd0, 1'b1, 1'b1);
        chk_all("lowarr.done", 32'h0000_0000, 1'b0, 5'd0, 6'd0);

        // Same-edge ack and re-request: set wins, grant returns after bubble.
        step(1'b1, 32'h0000_0080, 1'b1, 1'b0);
        step(1'b1, 32'd0, 1'b1, 1'b0);
        chk_all("setwin.grant7", 32'h0000_0080, 1'b1, 5'd7, 6'd1);
        step(1'b1, 32'h0000_0080, 1'b1, 1'b1);
        chk_all("setwin.bubble", 32'h0000_0080, 1'b0, 5'd0, 6'd1);
        step(1'b1, 32'd0, 1'b1, 1'b0);
        chk_all("setwin.regrant", 32'h0000_0080, 1'b1, 5'd7, 6'd1);
        step(1'b1, 32'd0, 1'b1, 1'b1);
        chk_all("setwin.done", 32'h0000_0000, 1'b0, 5'd0, 6'd0);

        // Reset during a grant with every bit pending; req/ack at that edge ignored.
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk_all("rstg.full", 32'hFFFF_FFFF, 1'b0, 5'd0, 6'd32);
        step(1'b1, 32'd0, 1'b1, 1'b0);
        chk_all("rstg.grant", 32'hFFFF_FFFF, 1'b1, 5'd0, 6'd32);
        step(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk_all("rstg.reset", 32'h0000_0000, 1'b0, 5'd0, 6'd0);
        step(1'b1, 32'd0, 1'b1, 1'b0);
        chk_all("rstg.after0", 32'h0000_0000, 1'b0, 5'd0, 6'd0);
        step(1'b1, 32'd0, 1'b1, 1'b0);
        chk_all("rstg.after1", 32'h0000_0000, 1'b0, 5'd0, 6'd0);

        // Randomized traffic against the reference model.
        step(1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 149) != 0);
            q = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 59) == 0) q = 32'hFFFF_FFFF;
            if ($urandom_range(0, 3) == 0) q = 32'd0;
            e = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 1) != 0);
            step(r, q, e, a);
            chk_all($sformatf("rand%0d", i), m_pend, m_v, m_d, 6'($countones(m_pend)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
